// File: rtl/delay_ctrl.sv
// delay_ctrl: address/enable sequencer for a RAM delay line (clk, rst, en, load, delay -> wr_addr, rd_addr, wr_en, rd_en, out_valid, filling, cur_delay)
module delay_ctrl #(
  parameter int A_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               load,
  input  logic [A_WIDTH-1:0] delay,
  output logic [A_WIDTH-1:0] wr_addr,
  output logic [A_WIDTH-1:0] rd_addr,
  output logic               wr_en,
  output logic               rd_en,
  output logic               out_valid,
  output logic               filling,
  output logic [A_WIDTH-1:0] cur_delay
);
  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
  state_t state_q, state_d;
  logic [A_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [A_WIDTH-1:0] fill_cnt_q, fill_cnt_d, cur_delay_q, cur_delay_d;
  logic out_valid_q, out_valid_d, filling_q, filling_d, strobe, fill_done;
  always_comb begin
    strobe = en && !load;
    wr_en = strobe && state_q != IDLE;
    rd_en = strobe && state_q == RUN;
    fill_done = wr_en && state_q == FILL && fill_cnt_q == cur_delay_q - A_WIDTH'(1);
    cur_delay_d = load ? (delay == '0 ? A_WIDTH'(1) : delay) : cur_delay_q;
    fill_cnt_d = load ? '0 : fill_cnt_q + A_WIDTH'(wr_en && state_q == FILL);
    wr_addr_d = wr_addr_q + A_WIDTH'(wr_en);
    state_d = load ? FILL : fill_done ? RUN : state_q;
    rd_addr_d = wr_addr_d - cur_delay_d;
    out_valid_d = rd_en;
    filling_d = state_d == FILL;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      fill_cnt_q <= '0;
      cur_delay_q <= '0;
      out_valid_q <= 1'b0;
      filling_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      fill_cnt_q <= fill_cnt_d;
      cur_delay_q <= cur_delay_d;
      out_valid_q <= out_valid_d;
      filling_q <= filling_d;
    end
  end
  assign wr_addr = wr_addr_q;
  assign rd_addr = rd_addr_q;
  assign cur_delay = cur_delay_q;
  assign out_valid = out_valid_q;
  assign filling = filling_q;
endmodule
